popcount_accumulator: RTL and testbench

POPCOUNT_ACCUMULATOR -- requirements
Module: popcount_accumulator

---
 rtl/popcount_accumulator.sv | 168 ++++++++++++++++
 tb/tb_popcount_accumulator.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_accumulator.sv
// popcount_accumulator
//   Counts the ones in every accepted input beat and accumulates them over a
//   frame delimited by last_i. When the frame ends, the total ones, the beat
//   count and an overflow flag are held on the output until downstream takes
//   them. After each frame there is one idle cycle before the next beat is
//   accepted.
//
//   Ports
//     clk_i       clock, rising edge
//     rst_ni      asynchronous active-low reset
//     clear_i     synchronous abort of the current frame and any held result
//     valid_i     input beat valid
//     ready_o     input beat accepted when valid_i && ready_o
//     data_i      input beat, INPUT_WIDTH bits
//     last_i      final beat of the frame (qualified by the input handshake)
//     valid_o     frame result valid
//     ready_i     result consumed when valid_o && ready_i
//     sum_o       total ones in the frame
//     beats_o     number of beats counted in the frame
//     overflow_o  frame had more than MAX_BEATS beats

// popcount_tree
//   Combinational balanced adder tree returning the number of ones in data_i.
//   The input is zero-padded up to the next power of two. Nodes are stored
//   heap-style: leaves at [N-1 .. 2N-2], the root at index 0.
//
//   Ports
//     data_i   input word, WIDTH bits
//     count_o  ones count, CNT_WIDTH bits
module popcount_tree #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0]     data_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    localparam int unsigned LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned N      = 1 << LEVELS;

    logic [CNT_WIDTH-1:0] node [0:2*N-2];

    for (genvar i = 0; i < N; i++) begin : g_leaf
        if (i < WIDTH) begin : g_bit
            assign node[N-1+i] = CNT_WIDTH'(data_i[i]);
        end else begin : g_pad
            assign node[N-1+i] = '0;
        end
    end

    // Every node's count fits CNT_WIDTH since it never exceeds WIDTH.
    for (genvar j = 0; j < N - 1; j++) begin : g_sum
        assign node[j] = node[2*j+1] + node[2*j+2];
    end

    assign count_o = node[0];

endmodule

module popcount_accumulator #(
    parameter int unsigned INPUT_WIDTH = 32,
    parameter int unsigned MAX_BEATS   = 256
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    input  logic [INPUT_WIDTH-1:0]               data_i,
    input  logic                                 last_i,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [$clog2(INPUT_WIDTH)+1+$clog2(MAX_BEATS)-1:0] sum_o,
    output logic [$clog2(MAX_BEATS):0]           beats_o,
    output logic                                 overflow_o
);

    localparam int unsigned CNT_WIDTH  = $clog2(INPUT_WIDTH) + 1;
    localparam int unsigned SUM_WIDTH  = CNT_WIDTH + $clog2(MAX_BEATS);
    localparam int unsigned BEAT_WIDTH = $clog2(MAX_BEATS) + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [SUM_WIDTH-1:0]  sum_q, sum_d;
    logic [BEAT_WIDTH-1:0] beats_q, beats_d;
    logic                  ovf_q, ovf_d;

    logic [CNT_WIDTH-1:0]  beat_count;
    logic                  in_hs;

    popcount_tree #(
        .WIDTH     (INPUT_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_popcount (
        .data_i  (data_i),
        .count_o (beat_count)
    );

    assign ready_o = (state_q == ACCUM);
    assign valid_o = (state_q == HOLD);
    assign in_hs   = valid_i && ready_o;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        beats_d = beats_q;
        ovf_d   = ovf_q;

        if (clear_i) begin
            state_d = ACCUM;
            sum_d   = '0;
            beats_d = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (in_hs) begin
                        // Beats past MAX_BEATS only mark overflow; the
                        // counters saturate so the sum can never wrap.
                        if (beats_q == BEAT_WIDTH'(MAX_BEATS)) begin
                            ovf_d = 1'b1;
                        end else begin
                            sum_d   = sum_q + SUM_WIDTH'(beat_count);
                            beats_d = beats_q + 1'b1;
                        end
                        if (last_i) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (ready_i) begin
                        state_d = ACCUM;
                        sum_d   = '0;
                        beats_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACCUM;
            sum_q   <= '0;
            beats_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            beats_q <= beats_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum_o      = sum_q;
    assign beats_o    = beats_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_popcount_accumulator.sv
module tb_popcount_accumulator;

    localparam int IW = 8;
    localparam int MB = 4;
    localparam int CW = $clog2(IW) + 1;
    localparam int SW = CW + $clog2(MB);
    localparam int BW = $clog2(MB) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          valid_i;
    logic          ready_o;
    logic [IW-1:0] data;
    logic          last;
    logic          valid_o;
    logic          ready_i;
    logic [SW-1:0] sum;
    logic [BW-1:0] beats;
    logic          ovf;

    always #5 clk = ~clk;

    popcount_accumulator #(
        .INPUT_WIDTH (IW),
        .MAX_BEATS   (MB)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (clear),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data),
        .last_i     (last),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .sum_o      (sum),
        .beats_o    (beats),
        .overflow_o (ovf)
    );

    typedef struct {
        int s;
        int b;
        int o;
    } res_t;

    res_t        exp_q[$];
    logic [7:0]  frame_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          rand_rdy = 1'b0;
    logic        rdy_force = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: a frame reports the ones in its first MB beats, the number
    // of beats counted (capped at MB) and whether more than MB beats arrived.
    task automatic model_beat(input logic [7:0] d, input logic l);
        res_t r;
        int   n;
        frame_q.push_back(d);
        if (l) begin
            n   = frame_q.size();
            r.s = 0;
            for (int i = 0; i < n && i < MB; i++) r.s += $countones(frame_q[i]);
            r.b = (n < MB) ? n : MB;
            r.o = (n > MB) ? 1 : 0;
            exp_q.push_back(r);
            frame_q.delete();
        end
    endtask

    // Drives one beat until accepted; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        bit r;
        bit ok = 1'b0;
        valid_i = 1'b1;
        data    = d;
        last    = l;
        while (!ok && n < 100) begin
            @(negedge clk);
            r = ready_o;
            @(posedge clk);
            #1;
            if (r) ok = 1'b1;
            n++;
        end
        valid_i = 1'b0;
        data    = 8'($urandom);
        last    = 1'($urandom);
        if (!ok) chk("send_timeout", 0, 1);
        else model_beat(d, l);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !ready_o) && n < 100) begin
            idle(1);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 0, 1);
    endtask

    // Downstream ready, updated away from the driver's own timestep.
    initial begin
        ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // Monitor: every cycle a result is presented it must match the oldest
    // expected result; it is retired when downstream takes it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("mon_sum", 32'(sum), exp_q[0].s);
                    chk("mon_beats", 32'(beats), exp_q[0].b);
                    chk("mon_ovf", 32'(ovf), exp_q[0].o);
                    chk("mon_ready_in_hold", 32'(ready_o), 0);
                    if (ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        clear   = 1'b0;
        valid_i = 1'b0;
        data    = '0;
        last    = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_beats", 32'(beats), 0);
        chk("rst_ovf", 32'(ovf), 0);
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Directed: 0xFF, 0x0F, 0x01(last) back to back.
        rdy_force = 1'b1;
        idle(1);
        send(8'hFF, 1'b0);
        send(8'h0F, 1'b0);
        send(8'h01, 1'b1);
        chk("d1_valid", 32'(valid_o), 1);
        chk("d1_sum", 32'(sum), 13);
        chk("d1_beats", 32'(beats), 3);
        chk("d1_ovf", 32'(ovf), 0);
        idle(1);
        chk("d1_valid_drop", 32'(valid_o), 0);
        chk("d1_ready_back", 32'(ready_o), 1);

        // Single zero beat: result valid for exactly one cycle.
        send(8'h00, 1'b1);
        chk("d2_valid", 32'(valid_o), 1);
        chk("d2_sum", 32'(sum), 0);
        chk("d2_beats", 32'(beats), 1);
        idle(1);
        chk("d2_valid_drop", 32'(valid_o), 0);

        // Held result with downstream stalled; beats during hold are ignored.
        rdy_force = 1'b0;
        idle(1);
        send(8'hAA, 1'b1);
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1;
            data    = 8'hFF;
            last    = 1'b1;
            @(negedge clk);
            chk("d3_ready_low", 32'(ready_o), 0);
            chk("d3_valid_high", 32'(valid_o), 1);
            chk("d3_sum", 32'(sum), 4);
            @(posedge clk);
            #1;
        end
        valid_i   = 1'b0;
        rdy_force = 1'b1;
        wait_idle();

        // Overflow: five 0xFF beats, then a clean frame.
        for (int i = 0; i < 5; i++) send(8'hFF, 1'(i == 4));
        chk("d4_sum", 32'(sum), 32);
        chk("d4_beats", 32'(beats), 4);
        chk("d4_ovf", 32'(ovf), 1);
        send(8'h03, 1'b1);
        chk("d4b_sum", 32'(sum), 2);
        chk("d4b_beats", 32'(beats), 1);
        chk("d4b_ovf", 32'(ovf), 0);

        // Clear mid-frame with a simultaneous beat.
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b0);
        valid_i = 1'b1;
        data    = 8'h01;
        last    = 1'b0;
        clear   = 1'b1;
        idle(1);
        clear   = 1'b0;
        valid_i = 1'b0;
        frame_q.delete();
        send(8'h07, 1'b1);
        chk("d5_sum", 32'(sum), 3);
        chk("d5_beats", 32'(beats), 1);
        wait_idle();

        // Clear while a result is held.
        rdy_force = 1'b0;
        idle(1);
        send(8'h0F, 1'b1);
        chk("d5b_valid", 32'(valid_o), 1);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        exp_q.delete();
        chk("d5b_valid_drop", 32'(valid_o), 0);
        chk("d5b_sum_zero", 32'(sum), 0);
        chk("d5b_ready", 32'(ready_o), 1);

        // Asynchronous reset while holding a result.
        send(8'hFF, 1'b1);
        chk("d6_sum", 32'(sum), 8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("d6_rst_valid", 32'(valid_o), 0);
        chk("d6_rst_sum", 32'(sum), 0);
        chk("d6_rst_ready", 32'(ready_o), 1);
        idle(2);
        rst_n = 1'b1;
        exp_q.delete();
        frame_q.delete();
        rdy_force = 1'b1;
        idle(1);
        chk("d6_post_valid", 32'(valid_o), 0);
        chk("d6_post_sum", 32'(sum), 0);
        chk("d6_post_ready", 32'(ready_o), 1);
        send(8'h01, 1'b1);
        chk("d6b_sum", 32'(sum), 1);
        wait_idle();

        // Random frames with random gaps and random downstream stalls.
        rand_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int b = 0; b < n; b++) begin
                idle($urandom_range(0, 2));
                send(8'($urandom), 1'(b == n - 1));
            end
        end

        rand_rdy  = 1'b0;
        rdy_force = 1'b1;
        wait_idle();
        chk("drain_pending", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
